// File: rtl/bus_pkg.sv
// Shared widths and state/grant types for the burst-bus memory responder.
package bus_pkg;

  localparam int unsigned ADDR_W = 28;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned ID_W   = 4;
  localparam int unsigned LEN_W  = 4;
  localparam int unsigned STRB_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    READ
  } resp_state_t;

  // Which channel won the most recent aw/ar contention.
  typedef enum logic {
    GRANT_READ,
    GRANT_WRITE
  } grant_t;

endpackage

// File: rtl/bus_resp_sram.sv
// Single-port word SRAM with per-byte write enables and a registered read port.
module bus_resp_sram
  import bus_pkg::*;
#(
  parameter int unsigned DEPTH     = 4096,
  parameter bit          INIT_ZERO = 1'b1
) (
  input  logic                     clk,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic                     we,
  input  logic [STRB_W-1:0]        be,
  input  logic [DATA_W-1:0]        wdata,
  input  logic                     re,
  output logic [DATA_W-1:0]        rdata
);

  if (INIT_ZERO) begin : g_zero
    logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};

    // Byte-masked write and one-cycle registered read.
    always_ff @(posedge clk) begin
      if (we) begin
        for (int unsigned i = 0; i < STRB_W; i++) begin
          if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
      if (re) rdata <= mem[addr];
    end
  end else begin : g_undef
    logic [DATA_W-1:0] mem [DEPTH];

    // Byte-masked write and one-cycle registered read.
    always_ff @(posedge clk) begin
      if (we) begin
        for (int unsigned i = 0; i < STRB_W; i++) begin
          if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
      if (re) rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/bus_mem_responder.sv
// Memory-side responder: serves one aw/w or ar/r burst at a time from a local SRAM.
module bus_mem_responder
  import bus_pkg::*;
#(
  parameter int unsigned DEPTH     = 4096,
  parameter bit          INIT_ZERO = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] awaddr,
  input  logic              awuserap,
  input  logic [ID_W-1:0]   awuserid,
  input  logic [LEN_W-1:0]  awlen,
  input  logic              awvalid,
  output logic              awready,
  input  logic [DATA_W-1:0] wdata,
  input  logic [STRB_W-1:0] wstrb,
  output logic              wready,
  output logic [ID_W-1:0]   wuserid,
  output logic              wlast,
  input  logic [ADDR_W-1:0] araddr,
  input  logic              aruserap,
  input  logic [ID_W-1:0]   aruserid,
  input  logic [LEN_W-1:0]  arlen,
  input  logic              arvalid,
  output logic              arready,
  output logic [DATA_W-1:0] rdata,
  output logic [ID_W-1:0]   rid,
  output logic              rvalid,
  output logic              rlast
);

  localparam int unsigned AW = $clog2(DEPTH);

  resp_state_t       state;
  grant_t            last_grant;
  logic [AW-1:0]     base;
  logic              ap;
  logic [ID_W-1:0]   id;
  logic [LEN_W-1:0]  len;
  logic [LEN_W-1:0]  beat;
  logic              rd_issue;
  logic [AW-1:0]     beat_addr;
  logic [DATA_W-1:0] sram_rdata;
  logic              contend;
  logic              unused_addr_hi;

  // Only the low AW address bits select a word.
  assign unused_addr_hi = ^{awaddr[ADDR_W-1:AW], araddr[ADDR_W-1:AW]};

  // Request arbitration: on contention grant the channel that lost last time.
  always_comb begin
    contend = awvalid & arvalid;
    awready = 1'b0;
    arready = 1'b0;
    if (state == IDLE) begin
      awready = awvalid & (~arvalid | (last_grant == GRANT_READ));
      arready = arvalid & (~awvalid | (last_grant == GRANT_WRITE));
    end
  end

  // Beat address wraps inside the memory; fixed bursts reuse the base.
  always_comb begin
    beat_addr = base + (ap ? AW'(beat) : '0);
  end

  // rdata is forced to zero whenever no read beat is being presented.
  assign rdata = rvalid ? sram_rdata : '0;

  bus_resp_sram #(
    .DEPTH     (DEPTH),
    .INIT_ZERO (INIT_ZERO)
  ) u_sram (
    .clk   (clk),
    .addr  (beat_addr),
    .we    (wready),
    .be    (wstrb),
    .wdata (wdata),
    .re    (rd_issue),
    .rdata (sram_rdata)
  );

  // Burst FSM; a read burst issues len+1 SRAM reads then spends one drain
  // cycle presenting the last beat before returning to IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= GRANT_READ;
      base       <= '0;
      ap         <= 1'b0;
      id         <= '0;
      len        <= '0;
      beat       <= '0;
      rd_issue   <= 1'b0;
      wready     <= 1'b0;
      wlast      <= 1'b0;
      wuserid    <= '0;
      rvalid     <= 1'b0;
      rlast      <= 1'b0;
      rid        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (awready) begin
            state   <= WRITE;
            base    <= awaddr[AW-1:0];
            ap      <= awuserap;
            id      <= awuserid;
            len     <= awlen;
            beat    <= '0;
            wready  <= 1'b1;
            wlast   <= (awlen == '0);
            wuserid <= awuserid;
          end else if (arready) begin
            state    <= READ;
            base     <= araddr[AW-1:0];
            ap       <= aruserap;
            id       <= aruserid;
            len      <= arlen;
            beat     <= '0;
            rd_issue <= 1'b1;
          end
          // The toggle only moves when both channels competed.
          if (contend) last_grant <= awready ? GRANT_WRITE : GRANT_READ;
        end
        WRITE: begin
          if (beat == len) begin
            state   <= IDLE;
            beat    <= '0;
            wready  <= 1'b0;
            wlast   <= 1'b0;
            wuserid <= '0;
          end else begin
            beat  <= beat + 1'b1;
            wlast <= ((beat + 1'b1) == len);
          end
        end
        READ: begin
          rvalid <= rd_issue;
          rlast  <= rd_issue & (beat == len);
          rid    <= rd_issue ? id : '0;
          if (rd_issue) begin
            if (beat == len) rd_issue <= 1'b0;
            else             beat     <= beat + 1'b1;
          end else begin
            state <= IDLE;
            beat  <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_mem_responder.sv
// Scoreboard bench for bus_mem_responder: drivers push expected beats, a monitor checks them.
module tb_bus_mem_responder;
  import bus_pkg::*;

  localparam int unsigned DEPTH = 4096;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [ADDR_W-1:0] awaddr = '0;
  logic              awuserap = 1'b0;
  logic [ID_W-1:0]   awuserid = '0;
  logic [LEN_W-1:0]  awlen = '0;
  logic              awvalid = 1'b0;
  logic              awready;
  logic [DATA_W-1:0] wdata = '0;
  logic [STRB_W-1:0] wstrb = '0;
  logic              wready;
  logic [ID_W-1:0]   wuserid;
  logic              wlast;
  logic [ADDR_W-1:0] araddr = '0;
  logic              aruserap = 1'b0;
  logic [ID_W-1:0]   aruserid = '0;
  logic [LEN_W-1:0]  arlen = '0;
  logic              arvalid = 1'b0;
  logic              arready;
  logic [DATA_W-1:0] rdata;
  logic [ID_W-1:0]   rid;
  logic              rvalid;
  logic              rlast;

  always #5 clk = ~clk;

  bus_mem_responder #(
    .DEPTH     (DEPTH),
    .INIT_ZERO (1'b1)
  ) dut (
    .clk(clk), .rst(rst),
    .awaddr(awaddr), .awuserap(awuserap), .awuserid(awuserid), .awlen(awlen),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wready(wready), .wuserid(wuserid), .wlast(wlast),
    .araddr(araddr), .aruserap(aruserap), .aruserid(aruserid), .arlen(arlen),
    .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rid(rid), .rvalid(rvalid), .rlast(rlast)
  );

  typedef struct {
    int          cyc;
    logic [31:0] data;
    logic [3:0]  id;
    logic        last;
  } exp_t;

  exp_t        wq[$];
  exp_t        rq[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  bit          ignore_r = 1'b0;
  logic [31:0] wd[16];
  logic [3:0]  ws[16];
  logic [31:0] rx[16];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic expired(input string name);
    total++;
    bad++;
    $display("FAIL %s act=timeout exp=handshake t=%0t", name, $time);
  endtask

  // Monitor: every presented beat must match the head of its expectation queue.
  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst) begin
      if (wready) begin
        if (wq.size() == 0) begin
          total++; bad++;
          $display("FAIL w_unexpected act=beat exp=none t=%0t", $time);
        end else begin
          e = wq.pop_front();
          chk("w_cycle", cyc, e.cyc);
          chk("wuserid", {28'b0, wuserid}, {28'b0, e.id});
          chk("wlast", {31'b0, wlast}, {31'b0, e.last});
        end
      end else begin
        chk("w_idle", {27'b0, wuserid, wlast}, 32'h0);
      end
      if (rvalid) begin
        if (!ignore_r) begin
          if (rq.size() == 0) begin
            total++; bad++;
            $display("FAIL r_unexpected act=%h exp=none t=%0t", rdata, $time);
          end else begin
            e = rq.pop_front();
            chk("r_cycle", cyc, e.cyc);
            chk("rdata", rdata, e.data);
            chk("rid", {28'b0, rid}, {28'b0, e.id});
            chk("rlast", {31'b0, rlast}, {31'b0, e.last});
          end
        end
      end else begin
        chk("r_idle_data", rdata, 32'h0);
        chk("r_idle_ctl", {27'b0, rid, rlast}, 32'h0);
      end
    end
  end

  task automatic do_write(input logic [27:0] a, input logic ap_i, input logic [3:0] id_i,
                          input logic [3:0] len_i, output int h);
    int c;
    int n;
    @(negedge clk);
    awaddr = a; awuserap = ap_i; awuserid = id_i; awlen = len_i; awvalid = 1'b1;
    n = 0;
    while (1) begin
      #1;
      if (awready) break;
      n++;
      if (n > 200) begin
        expired("aw_handshake");
        awvalid = 1'b0;
        h = -1;
        return;
      end
      @(negedge clk);
    end
    c = cyc;
    @(posedge clk);
    h = c + 1;
    #1 awvalid = 1'b0;
    for (int k = 0; k <= int'(len_i); k++)
      wq.push_back('{cyc: h + k, data: wd[k], id: id_i, last: (k == int'(len_i))});
    for (int k = 0; k <= int'(len_i); k++) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!wready && n < 50);
      if (!wready) begin
        expired("wready");
        return;
      end
      wdata = wd[k];
      wstrb = ws[k];
    end
    @(posedge clk);
    #1 wdata = '0;
    wstrb = '0;
  endtask

  task automatic do_read(input logic [27:0] a, input logic ap_i, input logic [3:0] id_i,
                         input logic [3:0] len_i, output int h, input bit push = 1'b1);
    int c;
    int n;
    @(negedge clk);
    araddr = a; aruserap = ap_i; aruserid = id_i; arlen = len_i; arvalid = 1'b1;
    n = 0;
    while (1) begin
      #1;
      if (arready) break;
      n++;
      if (n > 200) begin
        expired("ar_handshake");
        arvalid = 1'b0;
        h = -1;
        return;
      end
      @(negedge clk);
    end
    c = cyc;
    @(posedge clk);
    h = c + 1;
    #1 arvalid = 1'b0;
    if (push)
      for (int k = 0; k <= int'(len_i); k++)
        rq.push_back('{cyc: h + 1 + k, data: rx[k], id: id_i, last: (k == int'(len_i))});
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((rq.size() != 0 || wq.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) expired("drain");
    repeat (2) @(negedge clk);
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "bench did not finish");
  end

  initial begin : main
    int h, h1, h2, hw, hr;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_w", {27'b0, wready, wlast, wuserid}, 32'h0);
    chk("rst_r", {27'b0, rvalid, rlast, rid}, 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_ready", {30'b0, awready, arready}, 32'h0);
    rst = 1'b0;

    // Incrementing 4-beat write then read-back
    wd[0] = 32'hA0; wd[1] = 32'hA1; wd[2] = 32'hA2; wd[3] = 32'hA3;
    for (int i = 0; i < 16; i++) ws[i] = 4'hF;
    do_write(28'h10, 1'b1, 4'h5, 4'h3, h);
    drain();
    rx[0] = 32'hA0; rx[1] = 32'hA1; rx[2] = 32'hA2; rx[3] = 32'hA3;
    do_read(28'h10, 1'b1, 4'h9, 4'h3, h);
    drain();

    // Reset held 3 cycles in the middle of a 16-beat read
    ignore_r = 1'b1;
    do_read(28'h10, 1'b1, 4'h5, 4'hF, h, 1'b0);
    repeat (4) @(negedge clk);
    chk("midburst_rvalid", {31'b0, rvalid}, 32'h1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_r", {27'b0, rvalid, rlast, rid}, 32'h0);
    chk("rst_mid_rdata", rdata, 32'h0);
    chk("rst_mid_w", {27'b0, wready, wlast, wuserid}, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    ignore_r = 1'b0;
    do_read(28'h10, 1'b1, 4'h5, 4'h3, h);
    drain();

    // Byte strobes, including an all-zero strobe beat
    wd[0] = 32'h11223344; ws[0] = 4'hF;
    do_write(28'h20, 1'b1, 4'h2, 4'h0, h);
    wd[0] = 32'hAABBCCDD; ws[0] = 4'b0101;
    do_write(28'h20, 1'b1, 4'h2, 4'h0, h);
    wd[0] = 32'hFFFFFFFF; ws[0] = 4'h0;
    do_write(28'h20, 1'b1, 4'h3, 4'h0, h);
    ws[0] = 4'hF;
    rx[0] = 32'h11BB33DD;
    do_read(28'h20, 1'b1, 4'h1, 4'h0, h);
    drain();

    // Wrap from DEPTH-2; upper address bits ignored
    wd[0] = 32'hB0; wd[1] = 32'hB1; wd[2] = 32'hB2; wd[3] = 32'hB3;
    do_write(28'(DEPTH - 2), 1'b1, 4'h6, 4'h3, h);
    rx[0] = 32'hB0; rx[1] = 32'hB1; rx[2] = 32'hB2; rx[3] = 32'hB3;
    do_read(28'(DEPTH - 2), 1'b1, 4'h7, 4'h3, h);
    rx[0] = 32'hB2;
    do_read(28'hABC0000, 1'b1, 4'h8, 4'h0, h);
    rx[0] = 32'hB3;
    do_read(28'h1, 1'b1, 4'h8, 4'h0, h);
    drain();

    // Fixed-address bursts
    wd[0] = 32'h1; wd[1] = 32'h2; wd[2] = 32'h3;
    do_write(28'h7, 1'b0, 4'hA, 4'h2, h);
    rx[0] = 32'h3;
    do_read(28'h7, 1'b1, 4'hA, 4'h0, h);
    rx[0] = 32'h0;
    do_read(28'h8, 1'b1, 4'hA, 4'h0, h);
    rx[0] = 32'h3; rx[1] = 32'h3;
    do_read(28'h7, 1'b0, 4'hB, 4'h1, h);
    drain();

    // Contention: write wins first, read wins the next time
    wd[0] = 32'hD0; rx[0] = 32'hA0;
    fork
      do_write(28'h50, 1'b1, 4'hD, 4'h0, hw);
      do_read(28'h10, 1'b1, 4'hE, 4'h0, hr);
    join
    chk("arb_write_first", 32'(hw < hr), 32'h1);
    drain();
    wd[0] = 32'hD1;
    fork
      do_write(28'h51, 1'b1, 4'hD, 4'h0, hw);
      do_read(28'h10, 1'b1, 4'hE, 4'h0, hr);
    join
    chk("arb_read_first", 32'(hr < hw), 32'h1);
    drain();
    rx[0] = 32'hD0; rx[1] = 32'hD1;
    do_read(28'h50, 1'b1, 4'h3, 4'h1, h);
    drain();

    // Back-to-back reads: second accepted one idle cycle after rlast
    rx[0] = 32'hA0; rx[1] = 32'hA1; rx[2] = 32'hA2; rx[3] = 32'hA3;
    do_read(28'h10, 1'b1, 4'h2, 4'h3, h1);
    rx[0] = 32'hB0; rx[1] = 32'hB1;
    do_read(28'(DEPTH - 2), 1'b1, 4'h3, 4'h1, h2);
    chk("b2b_gap", h2 - h1, 32'd6);
    drain();

    // awvalid raised during a read burst waits until IDLE
    rx[0] = 32'hA0; rx[1] = 32'hA1; rx[2] = 32'hA2; rx[3] = 32'hA3;
    wd[0] = 32'hC0; wd[1] = 32'hC1;
    fork
      do_read(28'h10, 1'b1, 4'h4, 4'h3, hr);
      begin
        repeat (2) @(negedge clk);
        do_write(28'h40, 1'b1, 4'hC, 4'h1, hw);
      end
    join
    chk("aw_wait_gap", hw - hr, 32'd6);
    drain();
    rx[0] = 32'hC0; rx[1] = 32'hC1;
    do_read(28'h40, 1'b1, 4'hC, 4'h1, h);
    drain();

    chk("wq_empty", wq.size(), 32'h0);
    chk("rq_empty", rq.size(), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
